// File: rtl/dmem_responder.sv
// Fixed-latency RV32I data-memory responder: word-organised RAM with byte/half/word loads and stores.
// Optional misaligned-access trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misalign
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [3:0]     r_cnt;
    logic [3:0]     w_cnt_next;
    logic [AW+1:0]  r_addr;
    logic [31:0]    r_wdata;
    logic [2:0]     r_func3;
    logic           r_is_write;
    logic [31:0]    r_rdata;
    logic           r_done;
    logic           r_misalign;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_req;
    logic           w_accept;
    logic           w_commit;
    logic [AW-1:0]  w_idx;
    logic [31:0]    w_word;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [31:0]    w_load_data;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata_lanes;
    logic           w_misal;
    logic           w_addr_unused;

    assign w_req         = mem_read | mem_write;
    assign w_accept      = (r_state == ST_IDLE) & w_req;
    assign w_commit      = (r_state == ST_BUSY) & (r_cnt == 4'd0);
    assign w_idx         = r_addr[AW+1:2];
    assign w_word        = r_mem[w_idx];
    assign w_addr_unused = ^addr[31:AW+2];

    assign stall    = rst_n & (w_accept | (r_state == ST_BUSY));
    assign rdata    = r_rdata;
    assign done     = r_done;
    assign misalign = r_misalign;

    // Next-state and latency counter logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_next = ST_BUSY;
                    w_cnt_next   = CNT_LOAD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_RESP: w_state_next = ST_IDLE;
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Request capture; a simultaneous read+write is taken as a write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_func3    <= 3'd0;
            r_is_write <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= addr[AW+1:0];
            r_wdata    <= wdata;
            r_func3    <= func3;
            r_is_write <= mem_write;
        end else begin
            r_is_write <= r_is_write;
        end
    end

    // Store byte enables and lane replication
    always_comb begin
        w_be          = 4'b1111;
        w_wdata_lanes = r_wdata;
        case (r_func3[1:0])
            2'b00: begin
                w_be          = 4'b0001 << r_addr[1:0];
                w_wdata_lanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be          = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_lanes = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be          = 4'b1111;
                w_wdata_lanes = r_wdata;
            end
        endcase
    end

    // Load lane selection and extension
    always_comb begin
        w_byte = 8'd0;
        case (r_addr[1:0])
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            2'b11:   w_byte = w_word[31:24];
            default: w_byte = 8'd0;
        endcase
        w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
        case (r_func3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = w_word;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Alignment check on the captured access
    always_comb begin
        case (r_func3[1:0])
            2'b00:   w_misal = 1'b0;
            2'b01:   w_misal = r_addr[0];
            default: w_misal = (r_addr[1:0] != 2'b00);
        endcase
    end
`else
    assign w_misal = 1'b0;
`endif

    // Response registers; rdata only moves when a read commits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata    <= 32'd0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_done     <= w_commit;
            r_misalign <= w_commit & w_misal;
            if (w_commit && !r_is_write) begin
                r_rdata <= w_misal ? 32'd0 : w_load_data;
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && r_is_write && !w_misal) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY=2, DEPTH_WORDS=1024.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        misalign;

    int          n_cmp;
    int          n_err;
    logic [31:0] last_rd;
    logic [31:0] exp_q [$];
    logic        mis_q [$];

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .func3(func3), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .done(done), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_mis, input string name);
        int          stall_cycles;
        int          done_cycle;
        logic        got;
        logic [31:0] e;
        logic        em;
        if (wr) exp_q.push_back(last_rd);
        else begin
            exp_q.push_back(exp_rd);
            last_rd = exp_rd;
        end
        mis_q.push_back(exp_mis);
        mem_read = rd; mem_write = wr; func3 = f3; addr = a; wdata = wd;
        stall_cycles = 0; done_cycle = -1; got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                done_cycle = c;
                break;
            end
            if (stall) stall_cycles++;
            @(posedge clk); #1;
        end
        e  = exp_q.pop_front();
        em = mis_q.pop_front();
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL %s timeout: no done within 20 cycles", name);
        end else begin
            n_cmp += 4;
            if (rdata !== e) begin
                n_err++; $display("FAIL %s rdata: got %h expected %h", name, rdata, e);
            end
            if (misalign !== em) begin
                n_err++; $display("FAIL %s misalign: got %b expected %b", name, misalign, em);
            end
            if (done_cycle != LAT + 1) begin
                n_err++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cycle, LAT + 1);
            end
            if (stall_cycles != LAT + 1 || stall !== 1'b0) begin
                n_err++;
                $display("FAIL %s stall: got %0d cycles (resp stall=%b) expected %0d (0)",
                         name, stall_cycles, stall, LAT + 1);
            end
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || stall !== 1'b0) begin
            n_err++; $display("FAIL %s idle_after: got done=%b stall=%b expected 0 0", name, done, stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
        func3 = 3'b010; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0 || done !== 1'b0 || rdata !== 32'd0 || misalign !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: got stall=%b done=%b rdata=%h mis=%b expected 0 0 00000000 0",
                     stall, done, rdata, misalign);
        end
        @(posedge clk); #1;
        mem_read = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL reset_release: got stall=%b done=%b expected 0 0", stall, done);
        end
        @(posedge clk); #1;
        last_rd = 32'd0;
    endtask

    task automatic test_word();
        access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");
    endtask

    task automatic test_byte();
        access(1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0, "sw_10b");
        access(1'b0, 1'b1, 3'b000, 32'h13, 32'hAAAAAA80, 32'h0, 1'b0, "sb_13");
        access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, "lb_13");
        access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, "lbu_13");
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h80223344, 1'b0, "lw_10b");
        access(1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 32'h00000033, 1'b0, "lb_11");
    endtask

    task automatic test_half();
        access(1'b0, 1'b1, 3'b010, 32'h40, 32'h11223344, 32'h0, 1'b0, "sw_40");
        access(1'b0, 1'b1, 3'b001, 32'h42, 32'hABCD8001, 32'h0, 1'b0, "sh_42");
        access(1'b1, 1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFF8001, 1'b0, "lh_42");
        access(1'b1, 1'b0, 3'b101, 32'h42, 32'h0, 32'h00008001, 1'b0, "lhu_42");
        access(1'b1, 1'b0, 3'b001, 32'h40, 32'h0, 32'h00003344, 1'b0, "lh_40");
        access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h80013344, 1'b0, "lw_40");
        access(1'b1, 1'b0, 3'b111, 32'h40, 32'h0, 32'h80013344, 1'b0, "rsvd_40");
    endtask

    task automatic test_both_strobes();
        access(1'b1, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, "rw_30");
        access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, "lw_30");
    endtask

    task automatic test_misalign();
        access(1'b0, 1'b1, 3'b010, 32'h20, 32'h00000011, 32'h0, 1'b0, "sw_20");
`ifdef DMEM_MISALIGN_TRAP_EN
        access(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, 32'h00000000, 1'b1, "lw_22");
        access(1'b0, 1'b1, 3'b001, 32'h21, 32'h0000BEEF, 32'h0, 1'b1, "sh_21");
        access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h00000011, 1'b0, "lw_20m");
`else
        access(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, 32'h00000011, 1'b0, "lw_22");
        access(1'b0, 1'b1, 3'b001, 32'h21, 32'h0000BEEF, 32'h0, 1'b0, "sh_21");
        access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0000BEEF, 1'b0, "lw_20m");
`endif
    endtask

    task automatic test_reset_mid();
        access(1'b0, 1'b1, 3'b010, 32'h20, 32'h00000011, 32'h0, 1'b0, "sw_20_old");
        mem_write = 1'b1; func3 = 3'b010; addr = 32'h20; wdata = 32'h5;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b1) begin
            n_err++; $display("FAIL mid_req_stall: got %b expected 1", stall);
        end
        @(posedge clk); #1;
        rst_n = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_stall: got %b expected 0", stall);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_rd = 32'd0;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0 || done !== 1'b0 || rdata !== 32'd0) begin
            n_err++;
            $display("FAIL mid_rst_idle: got stall=%b done=%b rdata=%h expected 0 0 00000000",
                     stall, done, rdata);
        end
        @(posedge clk); #1;
        access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h00000011, 1'b0, "lw_20_after_rst");
    endtask

    task automatic test_wrap();
        access(1'b0, 1'b1, 3'b010, 32'h1000, 32'h00000007, 32'h0, 1'b0, "sw_1000");
        access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h00000007, 1'b0, "lw_0_wrap");
    endtask

    task automatic test_back_to_back();
        int   ndone;
        int   stall_cycles;
        int   dc [2];
        logic saw;
        exp_q.push_back(32'h80223344);
        exp_q.push_back(32'h80013344);
        last_rd = 32'h80013344;
        ndone = 0; stall_cycles = 0; dc[0] = -1; dc[1] = -1;
        mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010; addr = 32'h10;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            saw = done;
            if (stall) stall_cycles++;
            if (saw) begin
                n_cmp++;
                if (rdata !== exp_q[0]) begin
                    n_err++; $display("FAIL b2b_rdata%0d: got %h expected %h", ndone, rdata, exp_q[0]);
                end
                void'(exp_q.pop_front());
                dc[ndone] = c;
                ndone++;
            end
            if (ndone == 2) break;
            @(posedge clk); #1;
            if (saw) addr = 32'h40;
        end
        @(posedge clk); #1;
        mem_read = 1'b0;
        n_cmp += 2;
        if (ndone != 2 || dc[0] != LAT + 1 || dc[1] != 2 * LAT + 3) begin
            n_err++;
            $display("FAIL b2b_done: got %0d pulses at %0d,%0d expected 2 at %0d,%0d",
                     ndone, dc[0], dc[1], LAT + 1, 2 * LAT + 3);
        end
        if (stall_cycles != 2 * (LAT + 1)) begin
            n_err++; $display("FAIL b2b_stall: got %0d expected %0d", stall_cycles, 2 * (LAT + 1));
        end
        while (exp_q.size() > 0) void'(exp_q.pop_front());
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; last_rd = 32'd0;
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        func3 = 3'b000; addr = 32'd0; wdata = 32'd0;
        @(posedge clk); #1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_both_strobes();
        test_misalign();
        test_reset_mid();
        test_wrap();
        test_byte();
        test_half();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I core: the memory-side counterpart of the decoder's `mem_read`/`mem_write` strobes. It owns a word-organised data RAM and completes LB/LH/LW/LBU/LHU/SB/SH/SW accesses after a fixed, parameterised latency. While an access is in flight it holds `stall` high so the core freezes its PC and register write-back. It sits between the core's ALU address path and the register-file write-back mux.

## Interface

Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two, at least 2.
- `LATENCY`, default 2: number of BUSY cycles per access; legal range 1–15.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `mem_read`  in  1  load request from control.
- `mem_write`  in  1  store request from control.
- `func3`  in  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr`  in  32  byte address from the ALU.
- `wdata`  in  32  store data (rs2).
- `rdata`  out  32  extended load result.
- `stall`  out  1  high while an access is pending; the core must not advance.
- `done`  out  1  one-cycle pulse when an access completes.
- `misalign`  out  1  misaligned-access pulse; tied to 0 unless the macro is defined.

## Operation

- FSM states:
  - IDLE: no access in progress.
  - BUSY: down-counter `cnt` (4 bits) is running.
  - RESP: result is presented.
- IDLE to BUSY: on an edge where `mem_read | mem_write`, capture `addr`, `wdata`, `func3` and the op, and load `cnt = LATENCY-1`.
  - If both strobes are high, the access is a write; the read is dropped.
- BUSY:
  - If `cnt != 0`: decrement `cnt`.
  - If `cnt == 0`: commit the access at that edge and go to RESP. A write updates RAM; a read registers the extended data into `rdata`.
- RESP:
  - `done = 1`, `stall = 0`.
  - Go to IDLE at the next edge.
  - Strobes sampled in RESP are ignored, because they still belong to the completing instruction.
- `stall` is combinational: `(IDLE & (mem_read|mem_write)) | BUSY`. It is forced to 0 while `rst_n = 0`.
- Addressing:
  - Word index is `addr[log2(DEPTH_WORDS)+1:2]`; upper address bits are ignored, so accesses wrap modulo the RAM size.
  - Byte lane is `addr[1:0]`, little-endian.
- Stores:
  - SB writes the lane `addr[1:0]`.
  - SH writes the halfword selected by `addr[1]`.
  - SW writes all four bytes.
  - Unwritten bytes are preserved.
- Loads:
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - LW returns the full word.
- Reserved `func3` values (011, 110, 111) are treated as word access.
- `rdata` holds its value until the next read commits; writes never change it.
- RAM contents are not reset.

## Timing

- A request first seen in cycle 0 (IDLE) occupies BUSY in cycles 1..LATENCY and RESP in cycle LATENCY+1.
  - `stall` is high for LATENCY+1 cycles.
  - `done` and `rdata` are valid in cycle LATENCY+1.
- A back-to-back request from the next instruction is accepted in the IDLE cycle that follows RESP. Peak throughput is one access per LATENCY+2 cycles.
- Reset values: state IDLE, `cnt` 0, `rdata` 0, `done` 0, `misalign` 0, `stall` 0.
- Reset asserted mid-access: the FSM returns to IDLE and no write is committed unless its commit edge has already passed.
- A read-after-write to the same address observes the new data, because the writes are sequential.

## Configuration

- `DMEM_MISALIGN_TRAP_EN`
- Defined:
  - A halfword access with `addr[0] = 1` is misaligned; a word access with `addr[1:0] != 0` is misaligned.
  - A misaligned access runs the normal latency but does not write RAM.
  - For a misaligned read, `rdata` is set to 0.
  - `misalign` pulses together with `done`.
- Undefined:
  - `misalign` is constant 0.
  - Misaligned halfword accesses ignore `addr[0]`.
  - Misaligned word accesses ignore `addr[1:0]`.

## Test plan

- LATENCY=2: SW `addr`=0x10, `wdata`=0xDEADBEEF, then LW 0x10 → `stall` high for 3 cycles per access, `done` in cycle 3 of each, `rdata`=0xDEADBEEF.
- SB 0x13 ← 0x80 over word 0x11223344, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80223344.
- Both `mem_read` and `mem_write` high → treated as a write, RAM updated, `rdata` unchanged.
- `rst_n` low during BUSY of SW 0x20 ← 0x5 (before commit) → FSM in IDLE, `stall` 0, later LW 0x20 returns the old value.
- Macro defined: LW 0x22 → `misalign`=1 with `done`, `rdata`=0. SH 0x21 → RAM unchanged. Macro undefined: LW 0x22 returns the word at 0x20.
- `DEPTH_WORDS`=1024: SW 0x1000 ← 0x7 → LW 0x0 returns 0x7 (wrap-around).
